// File: rtl/bus_xfer_ctrl.sv
// Burst transfer controller that sits behind the bus arbiter. It runs the
// granted master's burst on the shared slave port and then pulses bus_ack.
module bus_xfer_ctrl #(
    parameter int N_MASTERS = 3,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int LEN_W     = 2,
    parameter int TIMEOUT   = 15
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_MASTERS-1:0]          bus_grant,
    output logic                          bus_ack,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [N_MASTERS-1:0]          m_we,
    input  logic [N_MASTERS*LEN_W-1:0]    m_len,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
    output logic [N_MASTERS-1:0]          m_wnext,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [N_MASTERS-1:0]          m_rvalid,
    output logic                          s_req,
    output logic                          s_we,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    input  logic [DATA_W-1:0]             s_rdata,
    input  logic                          s_ready,
    output logic                          xfer_err
);

    localparam int OWN_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [OWN_W-1:0]     owner_q, owner_d;
    logic [ADDR_W-1:0]    base_q, base_d;
    logic                 we_q, we_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [LEN_W-1:0]     beat_q, beat_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic                 err_q, err_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic [N_MASTERS-1:0] rvalid_q, rvalid_d;

    logic [OWN_W-1:0]     grant_idx;
    logic                 grant_any;
    logic                 grant_multi;
    logic [N_MASTERS-1:0] owner_mask;
    logic                 in_xfer;
    logic [TMO_W-1:0]     tmo_inc;

    // Lowest set bit wins; only meaningful when the grant is one-hot.
    always_comb begin
        grant_idx = '0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (bus_grant[i]) grant_idx = OWN_W'(i);
        end
    end

    assign grant_any   = |bus_grant;
    assign grant_multi = (bus_grant & (bus_grant - N_MASTERS'(1))) != '0;
    assign owner_mask  = N_MASTERS'(1) << owner_q;
    assign in_xfer     = (state_q == ST_XFER);
    assign tmo_inc     = tmo_q + TMO_W'(1);

    always_comb begin
        // NOTE: every _d gets a default first so no latch is inferred.
        state_d  = state_q;
        owner_d  = owner_q;
        base_d   = base_q;
        we_d     = we_q;
        len_d    = len_q;
        beat_d   = beat_q;
        tmo_d    = tmo_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        rvalid_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (grant_multi) begin
                    err_d = 1'b1;
                end else if (grant_any) begin
                    owner_d = grant_idx;
                    base_d  = m_addr[grant_idx*ADDR_W +: ADDR_W];
                    we_d    = m_we[grant_idx];
                    len_d   = m_len[grant_idx*LEN_W +: LEN_W];
                    beat_d  = '0;
                    tmo_d   = '0;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (s_ready) begin
                    beat_d = beat_q + LEN_W'(1);
                    tmo_d  = '0;
                    if (!we_q) begin
                        rdata_d  = s_rdata;
                        rvalid_d = owner_mask;
                    end
                    if (beat_q == len_q) state_d = ST_ACK;
                end else begin
                    tmo_d = tmo_inc;
                    // Slave left s_req unanswered for TIMEOUT cycles: drop the rest.
                    if (tmo_inc == TMO_W'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = ST_ACK;
                    end
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            base_q   <= '0;
            we_q     <= 1'b0;
            len_q    <= '0;
            beat_q   <= '0;
            tmo_q    <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= '0;
        end else begin
            // NOTE: state updates use non-blocking assignments only.
            state_q  <= state_d;
            owner_q  <= owner_d;
            base_q   <= base_d;
            we_q     <= we_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign bus_ack  = (state_q == ST_ACK);
    assign s_req    = in_xfer;
    assign s_we     = in_xfer & we_q;
    assign s_addr   = in_xfer ? (base_q + ADDR_W'(beat_q)) : '0;
    assign s_wdata  = in_xfer ? m_wdata[owner_q*DATA_W +: DATA_W] : '0;
    assign m_wnext  = (in_xfer && s_ready && we_q) ? owner_mask : '0;
    assign m_rdata  = rdata_q;
    assign m_rvalid = rvalid_q;
    assign xfer_err = err_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Self-checking bench for bus_xfer_ctrl: the bench plays arbiter, masters and
// a memory-backed slave, and predicts every beat from the burst description.
module tb_bus_xfer_ctrl;

    localparam int N   = 3;
    localparam int AW  = 8;
    localparam int DW  = 16;
    localparam int LW  = 2;
    localparam int TMO = 15;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    bus_grant;
    logic            bus_ack;
    logic [N*AW-1:0] m_addr;
    logic [N-1:0]    m_we;
    logic [N*LW-1:0] m_len;
    logic [N*DW-1:0] m_wdata;
    logic [N-1:0]    m_wnext;
    logic [DW-1:0]   m_rdata;
    logic [N-1:0]    m_rvalid;
    logic            s_req;
    logic            s_we;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic [DW-1:0]   s_rdata;
    logic            s_ready;
    logic            xfer_err;

    int            n_pass  = 0;
    int            n_total = 0;
    int            n_req;
    logic          exp_err;
    logic [DW-1:0] mem [256];

    bus_xfer_ctrl #(
        .N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .bus_grant(bus_grant), .bus_ack(bus_ack),
        .m_addr(m_addr), .m_we(m_we), .m_len(m_len), .m_wdata(m_wdata),
        .m_wnext(m_wnext), .m_rdata(m_rdata), .m_rvalid(m_rvalid),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ready(s_ready), .xfer_err(xfer_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        reset     = 1'b1;
        bus_grant = '0;
        s_ready   = 1'b0;
        @(negedge clk);
        #1;
        reset   = 1'b0;
        exp_err = 1'b0;
    endtask

    // Runs one burst starting in an IDLE cycle. rdy: 0..100 = percent chance of
    // s_ready per cycle, >100 = toggle 1,0,1,... Ends during the IDLE cycle.
    task automatic run_burst(input int m, input logic [AW-1:0] base, input logic we,
                             input int len, input int rdy, input bit keep,
                             input bit swap, output int nreq);
        int            beat, stall, cyc;
        bit            done, pend, took;
        logic [DW-1:0] exp_rd;
        logic [AW-1:0] ea;
        logic [N-1:0]  own;
        beat = 0; stall = 0; cyc = 0; done = 0; pend = 0; took = 0;
        exp_rd = '0; nreq = 0;
        own = N'(1) << m;
        for (int i = 0; i < N; i++) begin
            m_addr[i*AW +: AW]  = AW'($urandom);
            m_wdata[i*DW +: DW] = DW'($urandom);
            m_len[i*LW +: LW]   = LW'($urandom);
        end
        m_we = N'($urandom);
        m_addr[m*AW +: AW] = base;
        m_we[m]            = we;
        m_len[m*LW +: LW]  = LW'(len);
        bus_grant = own;
        s_ready   = 1'b0;
        @(negedge clk);
        while (!done && cyc < 200) begin
            if (took) m_wdata[m*DW +: DW] = DW'($urandom);
            if (swap && cyc == 1) bus_grant = (m == 0) ? 3'b010 : 3'b001;
            ea = base + AW'(beat);
            s_ready = (rdy > 100) ? ((cyc % 2) == 0) : ($urandom_range(99) < rdy);
            s_rdata = s_ready ? mem[ea] : DW'($urandom);
            #1;
            if (s_req) nreq++;
            n_total++; if (s_req !== 1'b1) $display("FAIL xfer_s_req: got %b want 1", s_req); else n_pass++;
            n_total++; if (s_addr !== ea) $display("FAIL xfer_s_addr: got %0h want %0h", s_addr, ea); else n_pass++;
            n_total++; if (s_we !== we) $display("FAIL xfer_s_we: got %b want %b", s_we, we); else n_pass++;
            if (we) begin
                n_total++;
                if (s_wdata !== m_wdata[m*DW +: DW]) $display("FAIL xfer_s_wdata: got %0h want %0h", s_wdata, m_wdata[m*DW +: DW]);
                else n_pass++;
            end
            n_total++;
            if (m_wnext !== ((s_ready && we) ? own : '0)) $display("FAIL xfer_wnext: got %b want %b", m_wnext, (s_ready && we) ? own : '0);
            else n_pass++;
            n_total++;
            if (m_rvalid !== (pend ? own : '0)) $display("FAIL xfer_rvalid: got %b want %b", m_rvalid, pend ? own : '0);
            else n_pass++;
            if (pend) begin
                n_total++; if (m_rdata !== exp_rd) $display("FAIL xfer_rdata: got %0h want %0h", m_rdata, exp_rd); else n_pass++;
            end
            n_total++; if (bus_ack !== 1'b0) $display("FAIL xfer_ack: got %b want 0", bus_ack); else n_pass++;
            n_total++; if (xfer_err !== exp_err) $display("FAIL xfer_err: got %b want %b", xfer_err, exp_err); else n_pass++;
            pend   = s_ready && !we;
            exp_rd = mem[ea];
            took   = s_ready && we;
            if (s_ready) begin
                if (we) mem[ea] = m_wdata[m*DW +: DW];
                beat++;
                stall = 0;
                if (beat > len) done = 1;
            end else begin
                stall++;
                if (stall == TMO) begin
                    done    = 1;
                    exp_err = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            n_total++;
            $display("FAIL burst_budget: burst still open after %0d cycles, want completion", cyc);
        end
        // ACK cycle
        s_ready = 1'b0;
        if (!keep) bus_grant = '0;
        #1;
        n_total++; if (bus_ack !== 1'b1) $display("FAIL ack_pulse: got %b want 1", bus_ack); else n_pass++;
        n_total++; if (s_req !== 1'b0) $display("FAIL ack_s_req: got %b want 0", s_req); else n_pass++;
        n_total++; if (m_wnext !== '0) $display("FAIL ack_wnext: got %b want 0", m_wnext); else n_pass++;
        n_total++; if (m_rvalid !== (pend ? own : '0)) $display("FAIL ack_rvalid: got %b want %b", m_rvalid, pend ? own : '0); else n_pass++;
        if (pend) begin
            n_total++; if (m_rdata !== exp_rd) $display("FAIL ack_rdata: got %0h want %0h", m_rdata, exp_rd); else n_pass++;
        end
        n_total++; if (xfer_err !== exp_err) $display("FAIL ack_err: got %b want %b", xfer_err, exp_err); else n_pass++;
        // IDLE cycle
        @(negedge clk);
        #1;
        n_total++; if (bus_ack !== 1'b0) $display("FAIL idle_ack: got %b want 0", bus_ack); else n_pass++;
        n_total++; if (s_req !== 1'b0) $display("FAIL idle_s_req: got %b want 0", s_req); else n_pass++;
        n_total++; if (m_rvalid !== '0) $display("FAIL idle_rvalid: got %b want 0", m_rvalid); else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus_grant = '0; s_ready = 1'b0; s_rdata = '0;
        m_addr = '0; m_we = '0; m_len = '0; m_wdata = '0; exp_err = 1'b0;
        repeat (2) @(negedge clk);
        bus_grant = 3'b001; m_we = 3'b111; m_wdata = '1; s_ready = 1'b1;
        #1;
        n_total++; if (bus_ack !== 1'b0) $display("FAIL reset_ack: got %b want 0", bus_ack); else n_pass++;
        n_total++; if (s_req !== 1'b0 || s_we !== 1'b0) $display("FAIL reset_req_we: got %b%b want 00", s_req, s_we); else n_pass++;
        n_total++; if (m_wnext !== '0 || m_rvalid !== '0) $display("FAIL reset_pulses: got %b %b want 0 0", m_wnext, m_rvalid); else n_pass++;
        n_total++; if (xfer_err !== 1'b0) $display("FAIL reset_err: got %b want 0", xfer_err); else n_pass++;
        n_total++; if (s_addr !== '0 || s_wdata !== '0 || m_rdata !== '0)
            $display("FAIL reset_data: got %0h %0h %0h want 0 0 0", s_addr, s_wdata, m_rdata); else n_pass++;
        bus_grant = '0; s_ready = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        mem[8'h10] = 16'hBEEF;
        run_burst(0, 8'h10, 1'b0, 0, 100, 1'b0, 1'b0, n_req);
        n_total++; if (n_req !== 1) $display("FAIL single_read_cycles: got %0d want 1", n_req); else n_pass++;
        n_total++; if (m_rdata !== 16'hBEEF) $display("FAIL single_read_data: got %0h want beef", m_rdata); else n_pass++;
    endtask

    task automatic test_wrap_write();
        run_burst(2, 8'hFE, 1'b1, 3, 101, 1'b0, 1'b0, n_req);
        n_total++; if (n_req !== 7) $display("FAIL wrap_write_cycles: got %0d want 7", n_req); else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset();
        run_burst(0, 8'h33, 1'b0, 2, 0, 1'b0, 1'b0, n_req);
        n_total++; if (n_req !== TMO) $display("FAIL timeout_cycles: got %0d want %0d", n_req, TMO); else n_pass++;
        n_total++; if (xfer_err !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", xfer_err); else n_pass++;
    endtask

    task automatic test_illegal_grant();
        do_reset();
        bus_grant = 3'b011;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            n_total++; if (xfer_err !== 1'b1) $display("FAIL illegal_err: got %b want 1", xfer_err); else n_pass++;
            n_total++; if (s_req !== 1'b0 || bus_ack !== 1'b0) $display("FAIL illegal_no_xfer: got req=%b ack=%b want 0 0", s_req, bus_ack); else n_pass++;
        end
        bus_grant = '0;
        exp_err = 1'b1;
        run_burst(1, 8'h20, 1'b1, 1, 100, 1'b0, 1'b0, n_req);
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        m_addr[1*AW +: AW] = 8'h40; m_we[1] = 1'b0; m_len[1*LW +: LW] = 2'd2;
        bus_grant = 3'b010;
        @(negedge clk);
        s_ready = 1'b1; s_rdata = mem[8'h40];
        #1;
        n_total++; if (s_addr !== 8'h40) $display("FAIL midrst_beat0_addr: got %0h want 40", s_addr); else n_pass++;
        @(negedge clk);
        s_ready = 1'b1; s_rdata = mem[8'h41];
        #1;
        n_total++; if (m_rvalid !== 3'b010 || s_req !== 1'b1) $display("FAIL midrst_beat1: got rvalid=%b req=%b want 010 1", m_rvalid, s_req); else n_pass++;
        reset = 1'b1;
        #1;
        n_total++; if (s_req !== 1'b0 || bus_ack !== 1'b0) $display("FAIL midrst_drop: got req=%b ack=%b want 0 0", s_req, bus_ack); else n_pass++;
        n_total++; if (m_rvalid !== '0 || m_wnext !== '0) $display("FAIL midrst_pulses: got %b %b want 0 0", m_rvalid, m_wnext); else n_pass++;
        n_total++; if (s_addr !== '0) $display("FAIL midrst_addr: got %0h want 0", s_addr); else n_pass++;
        @(negedge clk);
        #1;
        n_total++; if (s_req !== 1'b0 || bus_ack !== 1'b0) $display("FAIL midrst_held: got req=%b ack=%b want 0 0", s_req, bus_ack); else n_pass++;
        s_ready = 1'b0; bus_grant = '0; reset = 1'b0; exp_err = 1'b0;
        run_burst(2, 8'h80, 1'b1, 1, 100, 1'b0, 1'b0, n_req);
    endtask

    task automatic test_back_to_back();
        do_reset();
        run_burst(1, AW'($urandom), 1'($urandom), $urandom_range(3), 70, 1'b1, 1'b0, n_req);
        run_burst(1, AW'($urandom), 1'($urandom), $urandom_range(3), 70, 1'b0, 1'b1, n_req);
        run_burst(2, AW'($urandom), 1'b1, 3, 70, 1'b1, 1'b1, n_req);
        run_burst(2, AW'($urandom), 1'b0, 3, 70, 1'b0, 1'b0, n_req);
    endtask

    task automatic test_random_bursts();
        do_reset();
        for (int k = 0; k < 30; k++) begin
            run_burst($urandom_range(N - 1), AW'($urandom), 1'($urandom), $urandom_range(3),
                      $urandom_range(100, 40), 1'b0, 1'($urandom), n_req);
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = DW'($urandom);
        test_reset();
        test_single_read();
        test_wrap_write();
        test_timeout();
        test_illegal_grant();
        test_reset_mid_burst();
        test_back_to_back();
        test_random_bursts();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
